mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Parametrised multicycle multiply/divide unit for the MIPS datapath (MULT, MULTU, DIV, DIVU).
//  Driven by the controller via a start/busy/done handshake; results land in internal HI/LO regs
//  that feed the MemParaReg writeback mux (for MFHI/MFLO). Shift-add multiply, restoring divide.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are each WIDTH bits; must be >= 4
//  CNT_W   $clog2(WIDTH)+1   iteration counter width (derived, not overridden)
// PORTS
//  clock     in   1       system clock, rising edge
//  reset     in   1       asynchronous, active-high; clears all state
//  start     in   1       request; sampled only in IDLE
//  op        in   2       mdu_op_t: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a         in   WIDTH   rs operand (multiplicand / dividend)
//  b         in   WIDTH   rt operand (multiplier / divisor)
//  busy      out  1       high in every state except IDLE
//  done      out  1       one-cycle pulse, HI/LO valid
//  div_zero  out  1       last accepted op was DIV/DIVU with b==0
//  hi        out  WIDTH   product[2W-1:W] or remainder
//  lo        out  WIDTH   product[W-1:0] or quotient
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; counter and work regs cleared.
//  Reset mid-operation aborts: no done pulse; HI/LO read 0.
//  States (mdu_state_t): IDLE, CALC, FIX, DONE.
//  IDLE: start=1 at edge 0 latches op, |a|, |b| (abs only for signed ops), result signs;
//   clears div_zero, goes to CALC with counter=WIDTH-1.
//   DIV/DIVU with b==0: IDLE->DONE directly, div_zero=1, HI/LO unchanged.
//  CALC: one iteration per cycle, exactly WIDTH cycles (cycles 1..WIDTH); counter==0 -> FIX.
//   mult: if multiplier LSB, add multiplicand into upper half of a 2W+1-bit acc; shift right 1.
//   div: shift {rem,quot} left 1; trial = rem - divisor (W+1 bits); if trial>=0 rem=trial, quot LSB=1.
//  FIX (cycle WIDTH+1): signed ops negate results by latched sign. MULT: 2W product negated if
//   a[W-1]^b[W-1]. DIV: quotient negated if a[W-1]^b[W-1], remainder takes sign of dividend.
//   HI/LO written at FIX->DONE edge.
//  DONE (cycle WIDTH+2): done=1, busy=1, then IDLE. Latency start->done = WIDTH+2 cycles;
//   divide-by-zero latency = 1 cycle.
//  start while busy (CALC/FIX/DONE) is ignored, not queued; a,b,op may change freely after edge 0.
//  Back-to-back: earliest next accept is the cycle after DONE.
//  Arithmetic rules: |MIN_INT| = 2^(W-1) held unsigned in W bits. DIV MIN/-1 -> LO=MIN, HI=0
//   (wraps, no trap). Unsigned ops never negate. Width rules: acc 2W+1, rem trial W+1.
//  HI/LO and div_zero hold between ops; only an accepted start or reset changes them.
// STRUCTURE
//  mdu_pkg: typedef enum logic[1:0] mdu_op_t {MDU_MULT,MDU_MULTU,MDU_DIV,MDU_DIVU};
//   typedef enum logic[1:0] mdu_state_t {IDLE,CALC,FIX,DONE}; function is_signed(mdu_op_t).
//  Single module; FSM and datapath in one file. No sub-module: the datapath is one shared
//   shift register with an adder/subtractor.
//  Controller gains MULT/DIV states that assert start and wait on done.
// TESTING (WIDTH=32 unless stated; cycle counted from start edge)
//  MULT a=FFFFFFFD(-3) b=00000005 -> hi=FFFFFFFF lo=FFFFFFF1, done pulse exactly at cycle 34
//  MULTU a=b=FFFFFFFF -> hi=FFFFFFFE lo=00000001; busy high cycles 1..34, low at 35
//  DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD hi=FFFFFFFF; DIVU same operands -> lo=7FFFFFFC hi=1
//  DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0, div_zero=0
//  DIVU a=100 b=0 -> done at cycle 1, div_zero=1, hi/lo unchanged from prior op
//  start pulsed at cycle 10 of a MULT -> ignored, single done; reset at cycle 20 -> no done,
//   hi=lo=0, busy=0 immediately
//  WIDTH=8 random sweep of all 4 ops vs $signed/$unsigned reference model, latency 10

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types for the multicycle multiply/divide unit: operation codes, FSM states
// and operation classification helpers.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mdu_state_t;

    function automatic logic is_signed(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit: shift-add multiply and restoring divide on magnitudes,
// sign fix-up in a final cycle, results held in HI/LO until the next accepted request.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Mult: {carry, product-hi, multiplier/product-lo}. Div: {0, remainder, dividend/quotient}.
    logic [2*WIDTH:0]   work_q, work_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, rem_sh, trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // MIN_INT negates to itself, which read as unsigned is exactly its magnitude.
    assign abs_a = (is_signed(op) && a[WIDTH-1]) ? -a : a;
    assign abs_b = (is_signed(op) && b[WIDTH-1]) ? -b : b;

    assign mul_sum = work_q[2*WIDTH:WIDTH] + {1'b0, opnd_q};
    assign rem_sh  = work_q[2*WIDTH-1:WIDTH-1];
    assign trial   = rem_sh - {1'b0, opnd_q};

    assign prod_fix = neg_q     ? -work_q[2*WIDTH-1:0]     : work_q[2*WIDTH-1:0];
    assign quot_fix = neg_q     ? -work_q[WIDTH-1:0]       : work_q[WIDTH-1:0];
    assign rem_fix  = rem_neg_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d   = is_div(op);
                    neg_d      = is_signed(op) & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rem_neg_d  = is_signed(op) & a[WIDTH-1];
                    div_zero_d = 1'b0;
                    cnt_d      = CNT_W'(WIDTH - 1);
                    if (is_div(op)) begin
                        work_d = {1'b0, {WIDTH{1'b0}}, abs_a};
                        opnd_d = abs_b;
                    end else begin
                        work_d = {1'b0, {WIDTH{1'b0}}, abs_b};
                        opnd_d = abs_a;
                    end
                    if (is_div(op) && (b == '0)) begin
                        div_zero_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                if (is_div_q) begin
                    // A set top bit means the trial subtraction went negative: restore.
                    if (!trial[WIDTH]) begin
                        work_d = {1'b0, trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
                    end else begin
                        work_d = {1'b0, rem_sh[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
                    end
                end else if (work_q[0]) begin
                    work_d = {1'b0, mul_sum, work_q[WIDTH-1:1]};
                end else begin
                    work_d = {1'b0, work_q[2*WIDTH:1]};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed WIDTH=32 cases plus a randomized WIDTH=8 sweep against an
// integer-arithmetic reference model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        start32, busy32, done32, dz32;
    mdu_op_t     op32;
    logic [31:0] a32, b32, hi32, lo32;

    logic        start8, busy8, done8, dz8;
    mdu_op_t     op8;
    logic [7:0]  a8, b8, hi8, lo8;

    mult_div_unit #(.WIDTH(32)) dut32 (
        .clock(clk), .reset(rst), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );

    mult_div_unit #(.WIDTH(8)) dut8 (
        .clock(clk), .reset(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [16:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: {div_zero, hi, lo} from plain integer arithmetic.
    function automatic logic [16:0] ref8(input mdu_op_t o, input logic [7:0] x, input logic [7:0] y,
                                         input logic [15:0] prev);
        int sx, sy, ux, uy, q, r;
        logic [31:0] p;
        sx = int'($signed(x));
        sy = int'($signed(y));
        ux = int'(x);
        uy = int'(y);
        case (o)
            MDU_MULT:  begin p = sx * sy; return {1'b0, p[15:0]}; end
            MDU_MULTU: begin p = ux * uy; return {1'b0, p[15:0]}; end
            MDU_DIV: begin
                if (y == 8'h00) return {1'b1, prev};
                q = sx / sy;
                r = sx % sy;
                return {1'b0, r[7:0], q[7:0]};
            end
            default: begin
                if (y == 8'h00) return {1'b1, prev};
                q = ux / uy;
                r = ux % uy;
                return {1'b0, r[7:0], q[7:0]};
            end
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Issues one request; returns the cycle (from the accepting edge) at which done was seen,
    // or 0 on timeout, and how many cycles before done showed busy low.
    task automatic run32(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int gaps);
        @(negedge clk);
        op32 = o; a32 = x; b32 = y; start32 = 1'b1;
        lat = 0;
        gaps = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start32 = 1'b0;
            op32 = mdu_op_t'(2'($urandom_range(0, 3)));
            a32 = $urandom;
            b32 = $urandom;
            if (done32) begin
                lat = k;
                break;
            end
            if (!busy32) gaps++;
        end
    endtask

    task automatic run8(input mdu_op_t o, input logic [7:0] x, input logic [7:0] y,
                        output int lat);
        @(negedge clk);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            if (done8) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat, gaps, ndone, first;
        logic [16:0] e;
        logic [15:0] prev8;
        mdu_op_t o;
        logic [7:0] x, y;

        rst = 1'b1;
        start32 = 1'b0; op32 = MDU_MULT; a32 = '0; b32 = '0;
        start8  = 1'b0; op8  = MDU_MULT; a8  = '0; b8  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy32, 1'b0);
        check("reset_done", done32, 1'b0);
        check("reset_dz", dz32, 1'b0);
        check("reset_hi", hi32, 32'h0);
        check("reset_lo", lo32, 32'h0);
        check("reset_busy8", busy8, 1'b0);

        run32(MDU_MULT, 32'hFFFF_FFFD, 32'h0000_0005, lat, gaps);
        check("mult_lat", lat, 34);
        check("mult_hi", hi32, 32'hFFFF_FFFF);
        check("mult_lo", lo32, 32'hFFFF_FFF1);
        check("mult_busy_gaps", gaps, 0);
        @(negedge clk);
        check("mult_done_pulse", done32, 1'b0);

        run32(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, gaps);
        check("multu_lat", lat, 34);
        check("multu_hi", hi32, 32'hFFFF_FFFE);
        check("multu_lo", lo32, 32'h0000_0001);
        check("multu_busy_gaps", gaps, 0);
        check("multu_busy_at_done", busy32, 1'b1);
        @(negedge clk);
        check("multu_busy_c35", busy32, 1'b0);

        run32(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, lat, gaps);
        check("div_lat", lat, 34);
        check("div_lo", lo32, 32'hFFFF_FFFD);
        check("div_hi", hi32, 32'hFFFF_FFFF);

        run32(MDU_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, lat, gaps);
        check("divu_lo", lo32, 32'h7FFF_FFFC);
        check("divu_hi", hi32, 32'h0000_0001);

        run32(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, gaps);
        check("divmin_lo", lo32, 32'h8000_0000);
        check("divmin_hi", hi32, 32'h0000_0000);
        check("divmin_dz", dz32, 1'b0);

        run32(MDU_DIVU, 32'h0000_0100, 32'h0000_0000, lat, gaps);
        check("div0_lat", lat, 1);
        check("div0_dz", dz32, 1'b1);
        check("div0_hi", hi32, 32'h0000_0000);
        check("div0_lo", lo32, 32'h8000_0000);
        @(negedge clk);
        check("div0_idle", busy32, 1'b0);
        check("div0_dz_hold", dz32, 1'b1);

        // A second start during CALC must be dropped.
        @(negedge clk);
        op32 = MDU_MULT; a32 = 32'd7; b32 = 32'd9; start32 = 1'b1;
        ndone = 0;
        first = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            start32 = (k == 10);
            if (k == 10) a32 = 32'd3;
            if (done32) begin
                ndone++;
                if (first == 0) first = k;
            end
        end
        check("ignore_ndone", ndone, 1);
        check("ignore_lat", first, 34);
        check("ignore_lo", lo32, 32'd63);
        check("ignore_hi", hi32, 32'd0);
        check("ignore_dz", dz32, 1'b0);

        // Reset in the middle of an operation.
        @(negedge clk);
        op32 = MDU_MULT; a32 = 32'd5; b32 = 32'd6; start32 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start32 = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("abort_busy", busy32, 1'b0);
        check("abort_hi", hi32, 32'd0);
        check("abort_lo", lo32, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done32) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_lo_hold", lo32, 32'd0);

        // Randomized WIDTH=8 sweep; model state restarts from zero after the reset above.
        prev8 = 16'h0000;
        for (int i = 0; i < 300; i++) begin
            o = mdu_op_t'(2'($urandom_range(0, 3)));
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 9))
                0: y = 8'h00;
                1: y = 8'hFF;
                2: begin x = 8'h80; y = 8'hFF; end
                3: x = 8'h80;
                default: ;
            endcase
            exp_q.push_back(ref8(o, x, y, prev8));
            run8(o, x, y, lat);
            e = exp_q.pop_front();
            check("rnd_lat", lat, (is_div(o) && y == 8'h00) ? 1 : 10);
            check("rnd_dz", dz8, e[16]);
            check("rnd_hi", hi8, e[15:8]);
            check("rnd_lo", lo8, e[7:0]);
            prev8 = e[15:0];
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
